// File: rtl/mac_sequencer_pkg.sv
// +------------------------------------------------------------------+
// | mac_sequencer_pkg : shared state encoding and overflow helper     |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package mac_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_X  = 3'd1,
    S_RD_H  = 3'd2,
    S_MUL   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  // Two's complement add overflows when both operands share a sign the sum lacks.
  function automatic logic add_overflow(input logic a_msb, input logic b_msb,
                                        input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mac_sequencer_datapath.sv
// +------------------------------------------------------------------+
// | mac_datapath : T/P operand registers, signed multiply, saturating |
// | accumulator with sticky overflow. rev 1.0                         |
// +------------------------------------------------------------------+
`default_nettype none

module mac_datapath
  import mac_sequencer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_t,
  input  logic              load_p,
  input  logic              acc_add,
  input  logic              acc_clear,
  input  logic              ovf_clear,
  input  logic              sat_en,
  input  logic [DATA_W-1:0] rdata,
  output logic [ACC_W-1:0]  acc_nxt,
  output logic              ovf
);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [DATA_W-1:0]          t_q, t_d;
  logic [ACC_W-1:0]           p_q, p_d;
  logic [ACC_W-1:0]           acc_q, acc_d;
  logic                       ovf_q, ovf_d;
  logic signed [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]           sum;
  logic                       sum_ovf;

  always_comb begin
    prod    = $signed(t_q) * $signed(rdata);
    sum     = acc_q + p_q;
    sum_ovf = add_overflow(acc_q[ACC_W-1], p_q[ACC_W-1], sum[ACC_W-1]);

    t_d   = load_t ? rdata : t_q;
    p_d   = load_p ? ACC_W'(prod) : p_q;
    acc_d = acc_q;
    ovf_d = ovf_clear ? 1'b0 : ovf_q;

    if (acc_clear) begin
      acc_d = '0;
    end else if (acc_add) begin
      if (sum_ovf) begin
        ovf_d = 1'b1;
        // A positive accumulator can only overflow upward, a negative one downward.
        acc_d = sat_en ? (acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum;
      end else begin
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      t_q   <= '0;
      p_q   <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      t_q   <= t_d;
      p_q   <= p_d;
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc_nxt = acc_d;
  assign ovf     = ovf_q;

endmodule

`default_nettype wire

// File: rtl/mac_sequencer.sv
// +------------------------------------------------------------------+
// | mac_sequencer : N-tap signed dot-product engine sequencing reads  |
// | from a shared synchronous data RAM. rev 1.0                       |
// +------------------------------------------------------------------+
`default_nettype none

module mac_sequencer
  import mac_sequencer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  taps,
  input  logic [ADDR_W-1:0] x_base,
  input  logic [ADDR_W-1:0] h_base,
  input  logic              x_dec,
  input  logic              acc_clr,
  input  logic              sat_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  result,
  output logic              ovf
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [ADDR_W-1:0]   xptr_q, xptr_d;
  logic [ADDR_W-1:0]   hptr_q, hptr_d;
  logic                x_dec_q, x_dec_d;
  logic                sat_en_q, sat_en_d;
  logic                p_valid_q, p_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_rd_en_q, mem_rd_en_d;
  logic [ACC_W-1:0]    result_q, result_d;

  logic                load_t, load_p, acc_add, acc_clear, ovf_clear;
  logic [ACC_W-1:0]    acc_nxt;

  mac_datapath #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_datapath (
    .clk       (clk),
    .reset     (reset),
    .load_t    (load_t),
    .load_p    (load_p),
    .acc_add   (acc_add),
    .acc_clear (acc_clear),
    .ovf_clear (ovf_clear),
    .sat_en    (sat_en_q),
    .rdata     (mem_rdata),
    .acc_nxt   (acc_nxt),
    .ovf       (ovf)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    xptr_d    = xptr_q;
    hptr_d    = hptr_q;
    x_dec_d   = x_dec_q;
    sat_en_d  = sat_en_q;
    p_valid_d = p_valid_q;
    load_t    = 1'b0;
    load_p    = 1'b0;
    acc_add   = 1'b0;
    acc_clear = 1'b0;
    ovf_clear = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          count_d   = taps;
          xptr_d    = x_base;
          hptr_d    = h_base;
          x_dec_d   = x_dec;
          sat_en_d  = sat_en;
          p_valid_d = 1'b0;
          acc_clear = acc_clr;
          ovf_clear = 1'b1;
          state_d   = (taps == '0) ? S_DONE : S_RD_X;
        end
      end
      S_RD_X: begin
        acc_add = p_valid_q;
        state_d = S_RD_H;
      end
      S_RD_H: begin
        load_t  = 1'b1;
        state_d = S_MUL;
      end
      S_MUL: begin
        load_p    = 1'b1;
        p_valid_d = 1'b1;
        xptr_d    = x_dec_q ? xptr_q - 1'b1 : xptr_q + 1'b1;
        hptr_d    = hptr_q + 1'b1;
        count_d   = count_q - 1'b1;
        state_d   = (count_q > CNT_W'(1)) ? S_RD_X : S_DRAIN;
      end
      S_DRAIN: begin
        acc_add   = 1'b1;
        p_valid_d = 1'b0;
        state_d   = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered against the upcoming state so they line up with it.
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    mem_rd_en_d = (state_d == S_RD_X) || (state_d == S_RD_H);
    mem_addr_d  = mem_addr_q;
    if (state_d == S_RD_X) begin
      mem_addr_d = xptr_d;
    end else if (state_d == S_RD_H) begin
      mem_addr_d = hptr_d;
    end
    result_d = (state_d == S_DONE) ? acc_nxt : result_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      xptr_q      <= '0;
      hptr_q      <= '0;
      x_dec_q     <= 1'b0;
      sat_en_q    <= 1'b0;
      p_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_rd_en_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      xptr_q      <= xptr_d;
      hptr_q      <= hptr_d;
      x_dec_q     <= x_dec_d;
      sat_en_q    <= sat_en_d;
      p_valid_q   <= p_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_en_q <= mem_rd_en_d;
      result_q    <= result_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_rd_en = mem_rd_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_sequencer.sv
// +------------------------------------------------------------------+
// | tb_mac_sequencer : directed runs against a dot-product model with |
// | per-cycle output comparison. rev 1.0                              |
// +------------------------------------------------------------------+
`default_nettype none

module tb_mac_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  taps = '0;
  logic [7:0]  x_base = '0;
  logic [7:0]  h_base = '0;
  logic        x_dec = 1'b0;
  logic        acc_clr = 1'b0;
  logic        sat_en = 1'b0;
  logic [7:0]  mem_addr;
  logic        mem_rd_en;
  logic [15:0] mem_rdata = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        ovf;

  mac_sequencer #(
    .DATA_W (16),
    .ACC_W  (32),
    .ADDR_W (8),
    .CNT_W  (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .taps      (taps),
    .x_base    (x_base),
    .h_base    (h_base),
    .x_dec     (x_dec),
    .acc_clr   (acc_clr),
    .sat_en    (sat_en),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [256];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  typedef struct {
    logic        busy;
    logic        done;
    logic        rd;
    logic [7:0]  addr;
    logic [31:0] res;
    logic        ovf;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  addr_log[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          done_cyc = -1;
  logic        chk_idle = 1'b0;
  logic [31:0] m_acc = '0;
  logic        m_ovf = 1'b0;
  logic [31:0] prev_res = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (mem_rd_en) addr_log.push_back(mem_addr);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("busy", 32'(busy), 32'(e.busy));
      chk("done", 32'(done), 32'(e.done));
      chk("rd_en", 32'(mem_rd_en), 32'(e.rd));
      chk("result_hold", result, e.res);
      if (e.rd) chk("addr", 32'(mem_addr), 32'(e.addr));
      if (e.done) begin
        chk("ovf", 32'(ovf), 32'(e.ovf));
        done_cyc = cyc;
      end
    end else if (chk_idle) begin
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
    end
  end

  // Dot product straight from the arithmetic definition, one clamp/wrap per tap.
  task automatic model_run(input int n, input logic [7:0] xb, input logic [7:0] hb,
                           input logic xd, input logic clr, input logic sat);
    longint s;
    longint p;
    logic [7:0] xa;
    logic [7:0] ha;
    if (clr) m_acc = '0;
    m_ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      xa = xd ? xb - 8'(i) : xb + 8'(i);
      ha = hb + 8'(i);
      p = longint'($signed(mem[xa])) * longint'($signed(mem[ha]));
      s = longint'($signed(m_acc)) + p;
      if (s > 64'sd2147483647 || s < -64'sd2147483648) begin
        m_ovf = 1'b1;
        m_acc = sat ? ((s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000) : s[31:0];
      end else begin
        m_acc = s[31:0];
      end
    end
  endtask

  task automatic run(input string tag, input int n, input logic [7:0] xb, input logic [7:0] hb,
                     input logic xd, input logic clr, input logic sat, input logic poke,
                     input logic [31:0] lit_res, input logic lit_ovf, input int lit_cyc);
    exp_t e;
    int   len;
    @(posedge clk); #1;
    taps = 8'(n); x_base = xb; h_base = hb; x_dec = xd; acc_clr = clr; sat_en = sat;
    start = 1'b1;
    model_run(n, xb, hb, xd, clr, sat);
    @(posedge clk); #1;
    start = 1'b0;
    addr_log.delete();
    cyc = 0;
    done_cyc = -1;
    len = (n == 0) ? 1 : 3 * n + 2;
    for (int c = 1; c <= len; c++) begin
      int ph;
      int i;
      ph = (c - 1) % 3;
      i  = (c - 1) / 3;
      e.busy = 1'b1;
      e.done = (c == len);
      e.rd   = (c <= 3 * n) && (ph != 2);
      e.addr = (ph == 0) ? (xd ? xb - 8'(i) : xb + 8'(i)) : hb + 8'(i);
      e.res  = (c == len) ? m_acc : prev_res;
      e.ovf  = m_ovf;
      exp_q.push_back(e);
    end
    prev_res = m_acc;
    if (poke) begin
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    for (int k = 0; k < 200 && exp_q.size() > 0; k++) @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d expected cycles unconsumed, required 0", tag, exp_q.size());
      exp_q.delete();
    end
    chk({tag, "_result"}, result, lit_res);
    chk({tag, "_ovf"}, 32'(ovf), 32'(lit_ovf));
    chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(lit_cyc));
  endtask

  logic [7:0] basic_addrs [6];
  logic [7:0] wrap_addrs [6];

  initial begin
    basic_addrs = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22};
    wrap_addrs  = '{8'h01, 8'hFE, 8'h00, 8'hFF, 8'hFF, 8'h00};
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = 16'd1; mem[8'h11] = 16'd2; mem[8'h12] = 16'd3;
    mem[8'h20] = 16'd4; mem[8'h21] = 16'd5; mem[8'h22] = 16'd6;
    mem[8'h30] = 16'hFFFD; mem[8'h40] = 16'd7;
    mem[8'h31] = 16'd5;    mem[8'h41] = 16'd5;
    for (int i = 0; i < 3; i++) begin
      mem[8'h50 + 8'(i)] = 16'h7FFF;
      mem[8'h60 + 8'(i)] = 16'h7FFF;
    end
    mem[8'h01] = 16'd2; mem[8'h00] = 16'd3; mem[8'hFF] = 16'd4; mem[8'hFE] = 16'd5;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk_idle = 1'b1;

    run("basic", 3, 8'h10, 8'h20, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0020, 1'b0, 11);
    chk("basic_addr_count", 32'(addr_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < addr_log.size(); i++)
      chk("basic_addr_seq", 32'(addr_log[i]), 32'(basic_addrs[i]));

    run("signed", 1, 8'h30, 8'h40, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFEB, 1'b0, 5);
    run("cont", 1, 8'h31, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0004, 1'b0, 5);
    run("sat", 3, 8'h50, 8'h60, 1'b0, 1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 11);
    run("wrapov", 3, 8'h50, 8'h60, 1'b0, 1'b1, 1'b0, 1'b0, 32'hBFFD_0003, 1'b1, 11);

    run("ptrwrap", 3, 8'h01, 8'hFE, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0022, 1'b0, 11);
    chk("wrap_addr_count", 32'(addr_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < addr_log.size(); i++)
      chk("wrap_addr_seq", 32'(addr_log[i]), 32'(wrap_addrs[i]));

    run("n0_hold", 0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0022, 1'b0, 1);
    run("n0_clr", 0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1);
    run("poke", 3, 8'h10, 8'h20, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0020, 1'b0, 11);

    // Abort an N=3 run by asserting reset during cycle 5.
    chk_idle = 1'b0;
    @(posedge clk); #1;
    taps = 8'd3; x_base = 8'h10; h_base = 8'h20; x_dec = 1'b0; acc_clr = 1'b1; sat_en = 1'b0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    m_acc = '0; m_ovf = 1'b0; prev_res = '0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_rd_en", 32'(mem_rd_en), 32'd0);
    chk_idle = 1'b1;
    repeat (4) @(posedge clk);

    run("after_abort", 3, 8'h10, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0020, 1'b0, 11);
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
